mm_host_bridge: RTL and testbench

MM_HOST_BRIDGE -- requirements
Module: mm_host_bridge

---
 rtl/mm_pkg.sv | 22 ++
 rtl/mm_buf_ram.sv | 34 +++
 rtl/mm_host_bridge.sv | 193 +++++++++++++++++++
 tb/tb_mm_host_bridge.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg -- shared definitions for the matrix-multiplier host bridge.
//   mm_state_t : bridge state encoding (IDLE=0, FILL=1, RUN=2, DRAIN=3)
//   mm_n(l)    : matrix dimension N = 2**l
//   mm_m(l)    : matrix element count M = N*N
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } mm_state_t;

    function automatic int mm_n(input int l);
        return 32'sd1 << l;
    endfunction

    function automatic int mm_m(input int l);
        return mm_n(l) * mm_n(l);
    endfunction

endpackage

// File: rtl/mm_buf_ram.sv
// mm_buf_ram -- operand/result buffer, 2**ADDR_W words of BITWIDTH bits.
// One synchronous write port and two asynchronous read ports; no reset, so
// contents survive across jobs and across bridge resets.
//   clk              : write clock
//   we/waddr/wdata   : write port
//   raddr_a/rdata_a  : read port A (multiplier memory port)
//   raddr_b/rdata_b  : read port B (outbound drain path)
module mm_buf_ram #(
    parameter int ADDR_W   = 7,
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [BITWIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]   raddr_a,
    output logic [BITWIDTH-1:0] rdata_a,
    input  logic [ADDR_W-1:0]   raddr_b,
    output logic [BITWIDTH-1:0] rdata_b
);

    logic [BITWIDTH-1:0] mem_r [2**ADDR_W];

    // Single write port; storage is intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_r[raddr_a];
    assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/mm_host_bridge.sv
// mm_host_bridge -- streams two NxN operand matrices into a buffer RAM,
// starts an external multiplier that works in place on the RAM through a
// responder memory port, then streams the M result words (words 0..M-1) out.
//   clk, reset                          : clock, async active-high reset
//   s_data/s_valid/s_ready/s_last       : inbound operand stream (A then B)
//   m_data/m_valid/m_ready/m_last       : outbound result stream
//   mm_start/mm_done                    : multiplier start pulse / done
//   mm_addr/mm_we/mm_wrdata/mm_rddata   : multiplier memory port (RUN writes)
//   busy                                : high whenever not IDLE
//   err (MM_BRIDGE_LAST_CHECK_EN only)  : sticky s_last framing error
// Build option: define MM_BRIDGE_LAST_CHECK_EN to add the err port/logic.
module mm_host_bridge
    import mm_pkg::*;
#(
    parameter int L_RAM_SIZE = 3,
    parameter int BITWIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BITWIDTH-1:0]     s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    output logic [BITWIDTH-1:0]     m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    mm_start,
    input  logic                    mm_done,
    input  logic [2*L_RAM_SIZE:0]   mm_addr,
    input  logic                    mm_we,
    input  logic [BITWIDTH-1:0]     mm_wrdata,
    output logic [BITWIDTH-1:0]     mm_rddata,
    output logic                    busy
`ifdef MM_BRIDGE_LAST_CHECK_EN
    ,
    output logic                    err
`endif
);

    localparam int M  = mm_m(L_RAM_SIZE);
    localparam int AW = 2 * L_RAM_SIZE + 1;
    localparam logic [AW-1:0] LAST_WR = AW'(2 * M - 1);
    localparam logic [AW-2:0] LAST_RD = (AW-1)'(M - 1);

    mm_state_t             state_r, state_s;
    logic [AW-1:0]         wr_cnt_r, wr_cnt_s;
    logic [AW-2:0]         rd_cnt_r, rd_cnt_s;
    logic                  s_ready_r, m_valid_r, m_last_r, mm_start_r, busy_r;
    logic                  accept_s;
    logic                  ram_we_s;
    logic [AW-1:0]         ram_waddr_s;
    logic [BITWIDTH-1:0]   ram_wdata_s;
    logic [BITWIDTH-1:0]   drain_data_s;

    // s_ready_r is only ever high in FILL, so this is the FILL handshake.
    assign accept_s = s_valid & s_ready_r;

    // Next-state and counter update logic.
    always_comb begin
        state_s  = state_r;
        wr_cnt_s = wr_cnt_r;
        rd_cnt_s = rd_cnt_r;
        case (state_r)
            ST_IDLE: begin
                state_s  = ST_FILL;
                wr_cnt_s = '0;
                rd_cnt_s = '0;
            end
            ST_FILL: begin
                if (accept_s) begin
                    if (wr_cnt_r == LAST_WR) begin
                        state_s = ST_RUN;
                    end else begin
                        wr_cnt_s = wr_cnt_r + AW'(1);
                    end
                end else begin
                    wr_cnt_s = wr_cnt_r;
                end
            end
            ST_RUN: begin
                // mm_done in the start-pulse cycle belongs to a previous job.
                if (mm_done && !mm_start_r) begin
                    state_s  = ST_DRAIN;
                    rd_cnt_s = '0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (m_valid_r && m_ready) begin
                    if (rd_cnt_r == LAST_RD) begin
                        state_s = ST_IDLE;
                    end else begin
                        rd_cnt_s = rd_cnt_r + (AW-1)'(1);
                    end
                end else begin
                    rd_cnt_s = rd_cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // RAM write-port mux: stream words in FILL, multiplier writes in RUN.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = '0;
        ram_wdata_s = '0;
        case (state_r)
            ST_FILL: begin
                ram_we_s    = accept_s;
                ram_waddr_s = wr_cnt_r;
                ram_wdata_s = s_data;
            end
            ST_RUN: begin
                ram_we_s    = mm_we;
                ram_waddr_s = mm_addr;
                ram_wdata_s = mm_wrdata;
            end
            default: begin
                ram_we_s    = 1'b0;
                ram_waddr_s = '0;
                ram_wdata_s = '0;
            end
        endcase
    end

    // State, counters and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wr_cnt_r   <= '0;
            rd_cnt_r   <= '0;
            s_ready_r  <= 1'b0;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
            mm_start_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            wr_cnt_r   <= wr_cnt_s;
            rd_cnt_r   <= rd_cnt_s;
            s_ready_r  <= (state_s == ST_FILL);
            m_valid_r  <= (state_s == ST_DRAIN);
            m_last_r   <= (state_s == ST_DRAIN) && (rd_cnt_s == LAST_RD);
            mm_start_r <= (state_r == ST_FILL) && (state_s == ST_RUN);
            busy_r     <= (state_s != ST_IDLE);
        end
    end

`ifdef MM_BRIDGE_LAST_CHECK_EN
    logic err_r;

    // Sticky framing error: s_last must coincide exactly with the final word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (accept_s && (s_last != (wr_cnt_r == LAST_WR))) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    logic unused_s_last_s;
    assign unused_s_last_s = s_last;
`endif

    mm_buf_ram #(
        .ADDR_W   (AW),
        .BITWIDTH (BITWIDTH)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we_s),
        .waddr   (ram_waddr_s),
        .wdata   (ram_wdata_s),
        .raddr_a (mm_addr),
        .rdata_a (mm_rddata),
        .raddr_b ({1'b0, rd_cnt_r}),
        .rdata_b (drain_data_s)
    );

    assign s_ready  = s_ready_r;
    assign m_valid  = m_valid_r;
    assign m_last   = m_last_r;
    assign m_data   = drain_data_s;
    assign mm_start = mm_start_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_mm_host_bridge.sv
// tb_mm_host_bridge -- directed self-checking bench for mm_host_bridge with
// L_RAM_SIZE=2 (N=4, M=16, 32 input beats). The bench plays the multiplier:
// on mm_start it reads the operands back over the memory port, writes the
// product it computed from its own copy of the stream, then raises mm_done.
module tb_mm_host_bridge;

    localparam int L  = 2;
    localparam int BW = 32;
    localparam int N  = 4;
    localparam int M  = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] s_data;
    logic          s_valid, s_ready, s_last;
    logic [BW-1:0] m_data;
    logic          m_valid, m_ready, m_last;
    logic          mm_start, mm_done;
    logic [AW-1:0] mm_addr;
    logic          mm_we;
    logic [BW-1:0] mm_wrdata, mm_rddata;
    logic          busy;
`ifdef MM_BRIDGE_LAST_CHECK_EN
    logic          err;
`endif

    int checks = 0;
    int errors = 0;
    int start_pulses = 0;

    logic [BW-1:0] stream [2*M];
    logic [BW-1:0] exp_c  [M];

    mm_host_bridge #(.L_RAM_SIZE(L), .BITWIDTH(BW)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .mm_start(mm_start), .mm_done(mm_done),
        .mm_addr(mm_addr), .mm_we(mm_we), .mm_wrdata(mm_wrdata), .mm_rddata(mm_rddata),
        .busy(busy)
`ifdef MM_BRIDGE_LAST_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mm_start === 1'b1) start_pulses++;
    end

    // Reference product C = A * B from the bench's own copy of the stream.
    task automatic compute_expected();
        logic [BW-1:0] acc;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 32'd0;
                for (int k = 0; k < N; k++) begin
                    acc = acc + stream[i*N+k] * stream[M + k*N + j];
                end
                exp_c[i*N+j] = acc;
            end
        end
    endtask

    task automatic fill(input bit gaps, input int last_beat);
        for (int i = 0; i < 2*M; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready beat %0d: s_ready=%b expected 1", i, s_ready);
            end
            s_valid = 1'b1;
            s_data  = stream[i];
            s_last  = (i == last_beat);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_mult(input bit done_on_start);
        bit ok;
        checks++;
        if (mm_start !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: mm_start=%b expected 1", mm_start);
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_s_ready: s_ready=%b expected 0", s_ready);
        end
        if (done_on_start) mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
        checks++;
        if (mm_start !== 1'b0) begin
            errors++;
            $display("FAIL start_width: mm_start=%b expected 0", mm_start);
        end
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL still_run: m_valid=%b busy=%b expected 0 1", m_valid, busy);
        end
        ok = 1'b1;
        for (int a = 0; a < 2*M; a++) begin
            mm_addr = a[AW-1:0];
            #1;
            if (mm_rddata !== stream[a]) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ram_contents: buffer differs from sent stream (got %0d expected %0d)", 0, 1);
        end
        @(negedge clk);
        compute_expected();
        for (int idx = 0; idx < M; idx++) begin
            mm_we     = 1'b1;
            mm_addr   = idx[AW-1:0];
            mm_wrdata = exp_c[idx];
            @(negedge clk);
        end
        mm_we   = 1'b0;
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
    endtask

    task automatic drain(input int stall_at, input bit we_noise);
        if (we_noise) begin
            mm_we     = 1'b1;
            mm_addr   = 5'd5;
            mm_wrdata = 32'hDEAD_BEEF;
        end
        for (int k = 0; k < M; k++) begin
            checks++;
            if (m_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_valid beat %0d: m_valid=%b expected 1", k, m_valid);
            end
            checks++;
            if (m_data !== exp_c[k]) begin
                errors++;
                $display("FAIL drain_data beat %0d: m_data=%h expected %h", k, m_data, exp_c[k]);
            end
            checks++;
            if (m_last !== (k == M-1)) begin
                errors++;
                $display("FAIL drain_last beat %0d: m_last=%b expected %b", k, m_last, (k == M-1));
            end
            if (k == stall_at) begin
                m_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    checks++;
                    if (m_data !== exp_c[k] || m_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_hold: m_data=%h m_valid=%b expected %h 1", m_data, m_valid, exp_c[k]);
                    end
                end
            end
            m_ready = 1'b1;
            @(negedge clk);
        end
        m_ready = 1'b0;
        mm_we   = 1'b0;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: busy=%b m_valid=%b m_last=%b expected 0 0 0", busy, m_valid, m_last);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL next_fill: busy=%b s_ready=%b expected 1 1", busy, s_ready);
        end
    endtask

    task automatic check_one_start(input int base);
        checks++;
        if (start_pulses - base !== 1) begin
            errors++;
            $display("FAIL start_count: pulses=%0d expected 1", start_pulses - base);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || mm_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b s_ready=%b m_valid=%b m_last=%b mm_start=%b expected all 0",
                     busy, s_ready, m_valid, m_last, mm_start);
        end
`ifdef MM_BRIDGE_LAST_CHECK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: err=%b expected 0", err);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL enter_fill: s_ready=%b busy=%b expected 1 1", s_ready, busy);
        end
    endtask

    // A = identity, B = 1..16, so the result is 1..16.
    task automatic test_identity();
        int base;
        for (int i = 0; i < M; i++) begin
            stream[i]     = ((i / N) == (i % N)) ? 32'd1 : 32'd0;
            stream[M + i] = 32'(i + 1);
        end
        base = start_pulses;
        fill(1'b0, 2*M-1);
        run_mult(1'b0);
        drain(-1, 1'b1);
        check_one_start(base);
    endtask

    task automatic test_gaps_stall();
        int base;
        for (int i = 0; i < 2*M; i++) begin
            stream[i] = 32'(i * 3 + 1);
        end
        base = start_pulses;
        fill(1'b1, 2*M-1);
        run_mult(1'b1);
        drain(6, 1'b0);
        check_one_start(base);
    endtask

    task automatic test_reset_in_run();
        int base;
        for (int i = 0; i < 2*M; i++) begin
            stream[i] = 32'(100 - i);
        end
        fill(1'b0, 2*M-1);
        checks++;
        if (mm_start !== 1'b1) begin
            errors++;
            $display("FAIL run_entry: mm_start=%b expected 1", mm_start);
        end
        reset   = 1'b1;
        mm_done = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || mm_start !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b mm_start=%b s_ready=%b expected 0 0 0", busy, mm_start, s_ready);
        end
        @(negedge clk);
        reset   = 1'b0;
        mm_addr = 5'd20;
        #1;
        checks++;
        if (mm_rddata !== stream[20]) begin
            errors++;
            $display("FAIL ram_persist: mm_rddata=%h expected %h", mm_rddata, stream[20]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stale_done: s_ready=%b m_valid=%b busy=%b expected 1 0 1", s_ready, m_valid, busy);
        end
        mm_done = 1'b0;
        for (int i = 0; i < 2*M; i++) begin
            stream[i] = 32'((i * 7) ^ 5);
        end
        base = start_pulses;
        fill(1'b0, 2*M-1);
        run_mult(1'b0);
        drain(-1, 1'b0);
        check_one_start(base);
    endtask

`ifdef MM_BRIDGE_LAST_CHECK_EN
    task automatic test_last_check();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clean: err=%b expected 0", err);
        end
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            s_last  = (i == 4);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b expected 1", err);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b expected 1", err);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b expected 0", err);
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        s_data    = '0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        m_ready   = 1'b0;
        mm_done   = 1'b0;
        mm_addr   = '0;
        mm_we     = 1'b0;
        mm_wrdata = '0;
        test_reset();
        test_identity();
        test_gaps_stall();
        test_reset_in_run();
`ifdef MM_BRIDGE_LAST_CHECK_EN
        test_last_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
